rf_wb_arbiter: RTL and testbench

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

---
 rtl/rf_wb_arbiter_pkg.sv | 19 +
 rtl/rr_arb2.sv | 44 ++++
 rtl/rf_wb_arbiter.sv | 91 +++++++++
 tb/tb_rf_wb_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_wb_arbiter_pkg.sv
// Shared CPU constants and writeback request type for the register-file
// writeback arbiter.
package rf_wb_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
    logic [DATA_W-1:0]     pc;
  } wb_req_t;

  function automatic logic is_live_addr(input logic [REG_ADDR_W-1:0] addr);
    return (addr != ZERO_REG);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester wins at once, contention goes to
// the requester that was not granted most recently.
module rr_arb2 #(
  parameter int PRIO_INIT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] valid,
  output logic [1:0] grant
);

  localparam logic FAV_INIT = (PRIO_INIT != 0) ? 1'b1 : 1'b0;

  logic fav_r;

  // Grant selection; nothing is granted while reset is high
  always_comb begin
    grant = 2'b00;
    if (reset) begin
      grant = 2'b00;
    end else begin
      case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = fav_r ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  // Favoured requester flips to the other side after every grant
  always_ff @(posedge clk) begin
    if (reset) begin
      fav_r <= FAV_INIT;
    end else if (grant[0]) begin
      fav_r <= 1'b1;
    end else if (grant[1]) begin
      fav_r <= 1'b0;
    end else begin
      fav_r <= fav_r;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: merges ALU/load and mult/div writebacks into
// one write port through a one-entry output stage with a bypass query.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int PRIO_INIT = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [REG_ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0]     req0_data,
  input  logic [DATA_W-1:0]     req0_pc,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [REG_ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0]     req1_data,
  input  logic [DATA_W-1:0]     req1_pc,
  output logic                  rf_en,
  output logic [REG_ADDR_W-1:0] rf_a3,
  output logic [DATA_W-1:0]     rf_wd,
  output logic [DATA_W-1:0]     rf_wpc,
  input  logic [REG_ADDR_W-1:0] q_addr,
  output logic                  q_hit,
  output logic [DATA_W-1:0]     q_data
);

  logic [1:0]            grant_s;
  wb_req_t               win_s;
  logic                  stage_valid_r;
  logic [REG_ADDR_W-1:0] stage_addr_r;
  logic [DATA_W-1:0]     stage_data_r;
  logic [DATA_W-1:0]     stage_pc_r;
  logic                  live_s;
  logic                  q_hit_s;

  rr_arb2 #(
    .PRIO_INIT (PRIO_INIT)
  ) u_rr_arb2 (
    .clk   (clk),
    .reset (reset),
    .valid ({req1_valid, req0_valid}),
    .grant (grant_s)
  );

  assign req0_ready = grant_s[0];
  assign req1_ready = grant_s[1];

  // Mux the granted request onto a single bundle
  always_comb begin
    win_s = '{addr: req0_addr, data: req0_data, pc: req0_pc};
    case (grant_s)
      2'b10:   win_s = '{addr: req1_addr, data: req1_data, pc: req1_pc};
      default: win_s = '{addr: req0_addr, data: req0_data, pc: req0_pc};
    endcase
  end

  // A write to the zero register consumes its grant but never enters the stage,
  // so the rf_* fields keep their previous values for it
  always_ff @(posedge clk) begin
    if (reset) begin
      stage_valid_r <= 1'b0;
      stage_addr_r  <= ZERO_REG;
      stage_data_r  <= {DATA_W{1'b0}};
      stage_pc_r    <= {DATA_W{1'b0}};
    end else if ((grant_s != 2'b00) && is_live_addr(win_s.addr)) begin
      stage_valid_r <= 1'b1;
      stage_addr_r  <= win_s.addr;
      stage_data_r  <= win_s.data;
      stage_pc_r    <= win_s.pc;
    end else begin
      stage_valid_r <= 1'b0;
      stage_addr_r  <= stage_addr_r;
      stage_data_r  <= stage_data_r;
      stage_pc_r    <= stage_pc_r;
    end
  end

  // A write still sitting in the stage when reset rises is discarded
  assign live_s  = stage_valid_r & ~reset;
  assign q_hit_s = live_s && (stage_addr_r == q_addr) && is_live_addr(q_addr);

  assign rf_en  = live_s;
  assign rf_a3  = stage_addr_r;
  assign rf_wd  = stage_data_r;
  assign rf_wpc = stage_pc_r;
  assign q_hit  = q_hit_s;
  assign q_data = q_hit_s ? stage_data_r : {DATA_W{1'b0}};

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios plus randomized
// traffic compared every cycle against a behavioural model.
module tb_rf_wb_arbiter;

  localparam int PRIO_INIT = 0;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [4:0]  req0_addr, req1_addr;
  logic [31:0] req0_data, req1_data;
  logic [31:0] req0_pc, req1_pc;
  logic        rf_en;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd, rf_wpc;
  logic [4:0]  q_addr;
  logic        q_hit;
  logic [31:0] q_data;

  int checks = 0;
  int errors = 0;

  rf_wb_arbiter #(.PRIO_INIT(PRIO_INIT)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
    .req0_data(req0_data), .req0_pc(req0_pc),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
    .req1_data(req1_data), .req1_pc(req1_pc),
    .rf_en(rf_en), .rf_a3(rf_a3), .rf_wd(rf_wd), .rf_wpc(rf_wpc),
    .q_addr(q_addr), .q_hit(q_hit), .q_data(q_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: who was favoured, and what the write port shows
  int          m_fav = PRIO_INIT;
  logic        m_en  = 1'b0;
  logic [4:0]  m_a3  = 5'd0;
  logic [31:0] m_wd  = 32'd0;
  logic [31:0] m_wpc = 32'd0;

  function automatic int winner();
    if (reset)                     return -1;
    if (req0_valid && req1_valid)  return m_fav;
    if (req0_valid)                return 0;
    if (req1_valid)                return 1;
    return -1;
  endfunction

  function automatic logic [4:0] win_addr();
    return (winner() == 1) ? req1_addr : req0_addr;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_fav <= PRIO_INIT;
      m_en  <= 1'b0;
      m_a3  <= 5'd0;
      m_wd  <= 32'd0;
      m_wpc <= 32'd0;
    end else if (winner() < 0) begin
      m_en <= 1'b0;
    end else begin
      m_fav <= 1 - winner();
      if (win_addr() != 5'd0) begin
        m_en  <= 1'b1;
        m_a3  <= win_addr();
        m_wd  <= (winner() == 1) ? req1_data : req0_data;
        m_wpc <= (winner() == 1) ? req1_pc : req0_pc;
      end else begin
        m_en <= 1'b0;
      end
    end
  end

  // Compare process: every negedge, DUT against model
  int  w0 = 0, w1 = 0;
  logic exp_en, exp_hit;
  always @(negedge clk) begin
    exp_en  = m_en && !reset;
    exp_hit = exp_en && (m_a3 == q_addr) && (q_addr != 5'd0);
    chk("m_ready0", {31'd0, req0_ready}, {31'd0, winner() == 0});
    chk("m_ready1", {31'd0, req1_ready}, {31'd0, winner() == 1});
    chk("m_rf_en",  {31'd0, rf_en}, {31'd0, exp_en});
    chk("m_rf_a3",  {27'd0, rf_a3}, {27'd0, m_a3});
    chk("m_rf_wd",  rf_wd, m_wd);
    chk("m_rf_wpc", rf_wpc, m_wpc);
    chk("m_q_hit",  {31'd0, q_hit}, {31'd0, exp_hit});
    chk("m_q_data", q_data, exp_hit ? m_wd : 32'd0);
    if (!reset && req0_valid && !req0_ready) begin
      chk("wait0_bound", w0, 0);
      w0 <= w0 + 1;
    end else begin
      w0 <= 0;
    end
    if (!reset && req1_valid && !req1_ready) begin
      chk("wait1_bound", w1, 0);
      w1 <= w1 + 1;
    end else begin
      w1 <= 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic new_req(input int which);
    logic [4:0]  a;
    logic [31:0] pcv;
    a   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 12));
    pcv = $urandom & 32'hFFFF_FFFC;
    if (which == 0) begin
      req0_valid = ($urandom_range(0, 3) != 0);
      req0_addr  = a; req0_data = $urandom; req0_pc = pcv;
    end else begin
      req1_valid = ($urandom_range(0, 3) != 0);
      req1_addr  = a; req1_data = $urandom; req1_pc = pcv;
    end
  endtask

  logic s0, s1;

  initial begin
    reset = 1'b1; q_addr = 5'd0;
    req0_valid = 1'b1; req0_addr = 5'd4; req0_data = 32'h0; req0_pc = 32'h0;
    req1_valid = 1'b1; req1_addr = 5'd6; req1_data = 32'h0; req1_pc = 32'h0;
    repeat (2) begin
      @(negedge clk);
      chk("rst_ready0", {31'd0, req0_ready}, 32'd0);
      chk("rst_ready1", {31'd0, req1_ready}, 32'd0);
      chk("rst_rf_en",  {31'd0, rf_en}, 32'd0);
      chk("rst_rf_a3",  {27'd0, rf_a3}, 32'd0);
      chk("rst_rf_wd",  rf_wd, 32'd0);
    end
    tick();

    // Lone req0 write to x5
    reset = 1'b0; req1_valid = 1'b0;
    req0_addr = 5'd5; req0_data = 32'h1234; req0_pc = 32'h100;
    @(negedge clk);
    chk("solo_ready0", {31'd0, req0_ready}, 32'd1);
    tick(); req0_valid = 1'b0;
    @(negedge clk);
    chk("solo_rf_en", {31'd0, rf_en}, 32'd1);
    chk("solo_rf_a3", {27'd0, rf_a3}, 32'd5);
    chk("solo_rf_wd", rf_wd, 32'h1234);
    chk("solo_rf_wpc", rf_wpc, 32'h100);

    // Sustained contention alternates 0,1,0,1 from a fresh reset
    tick(); reset = 1'b1; tick(); reset = 1'b0;
    req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'd10; req0_pc = 32'h200;
    req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 32'd20; req1_pc = 32'h300;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("alt_ready0", {31'd0, req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("alt_ready1", {31'd0, req1_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
      if (i > 0) chk("alt_rf_en", {31'd0, rf_en}, 32'd1);
      tick();
      if (i % 2 == 0) req0_data = req0_data + 32'd1;
      else            req1_data = req1_data + 32'd1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    chk("alt_rf_en_last", {31'd0, rf_en}, 32'd1);
    chk("alt_rf_wd_last", rf_wd, 32'd21);
    tick();

    // Write to x0 is accepted but never reaches the register file
    req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'h55; req1_pc = 32'h400;
    @(negedge clk);
    chk("x0_ready1", {31'd0, req1_ready}, 32'd1);
    tick(); req1_valid = 1'b0; q_addr = 5'd0;
    @(negedge clk);
    chk("x0_rf_en", {31'd0, rf_en}, 32'd0);
    chk("x0_q_hit", {31'd0, q_hit}, 32'd0);
    chk("x0_rf_wd_held", rf_wd, 32'd21);

    // Same destination from both sides lands in grant order
    tick(); reset = 1'b1; tick(); reset = 1'b0;
    req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'hAAAA_0001; req0_pc = 32'h500;
    req1_valid = 1'b1; req1_addr = 5'd9; req1_data = 32'hBBBB_0002; req1_pc = 32'h504;
    @(negedge clk);
    chk("same_ready0", {31'd0, req0_ready}, 32'd1);
    tick(); req0_valid = 1'b0;
    @(negedge clk);
    chk("same_wd_a", rf_wd, 32'hAAAA_0001);
    chk("same_ready1", {31'd0, req1_ready}, 32'd1);
    tick(); req1_valid = 1'b0;
    @(negedge clk);
    chk("same_wd_b", rf_wd, 32'hBBBB_0002);
    chk("same_a3", {27'd0, rf_a3}, 32'd9);
    tick();

    // Bypass query hits the staged write
    req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'h7777_0007; req0_pc = 32'h600;
    @(negedge clk);
    chk("byp_ready0", {31'd0, req0_ready}, 32'd1);
    tick(); req0_valid = 1'b0; q_addr = 5'd7;
    @(negedge clk);
    chk("byp_q_hit", {31'd0, q_hit}, 32'd1);
    chk("byp_q_data", q_data, 32'h7777_0007);
    tick(); q_addr = 5'd0;

    // Reset right after acceptance discards the write and restores the pointer
    req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h3333; req0_pc = 32'h700;
    @(negedge clk);
    chk("rst2_accept", {31'd0, req0_ready}, 32'd1);
    tick(); reset = 1'b1; req0_data = 32'h3334;
    req1_valid = 1'b1; req1_addr = 5'd8; req1_data = 32'h8888; req1_pc = 32'h704;
    @(negedge clk);
    chk("rst2_rf_en", {31'd0, rf_en}, 32'd0);
    chk("rst2_ready0", {31'd0, req0_ready}, 32'd0);
    chk("rst2_ready1", {31'd0, req1_ready}, 32'd0);
    tick(); reset = 1'b0;
    @(negedge clk);
    chk("rst2_prio0", {31'd0, req0_ready}, 32'd1);
    chk("rst2_prio1", {31'd0, req1_ready}, 32'd0);
    tick(); req0_valid = 1'b0; req1_valid = 1'b0;

    // Randomized traffic; requesters hold an offer until it is accepted
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      s0 = req0_ready; s1 = req1_ready;
      tick();
      if (!req0_valid || s0) new_req(0);
      if (!req1_valid || s1) new_req(1);
      reset  = ($urandom_range(0, 199) == 0);
      q_addr = ($urandom_range(0, 1) == 0) ? m_a3 : 5'($urandom_range(0, 31));
    end
    reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
